// File: rtl/mips_decode_alu_unit_if.sv
// Datapath bus for the MIPS decode/ALU/fetch-adder unit.
// The master drives stage inputs; the slave (the unit) returns results.
interface mips_decode_alu_unit_if;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [31:0] syscall_info;
    logic [31:0] syscall_arg;
    logic [1:0]  reg_dst;
    logic        jump;
    logic        jump_reg;
    logic        jump_link;
    logic        branch;
    logic        mem_read;
    logic        mem_to_reg;
    logic        mem_write;
    logic        reg_write;
    logic        alu_src;
    logic [2:0]  alu_ctrl_d;
    logic        illegal;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        halted;
    logic        print_valid;
    logic [31:0] print_data;

    modport master (
        output pc, instr, syscall_info, syscall_arg,
        output alu_a, alu_b, alu_ctrl,
        input  pc_plus4, reg_dst, jump, jump_reg, jump_link,
        input  branch, mem_read, mem_to_reg, mem_write,
        input  reg_write, alu_src, alu_ctrl_d, illegal,
        input  alu_out, alu_zero, halted, print_valid, print_data
    );

    modport slave (
        input  pc, instr, syscall_info, syscall_arg,
        input  alu_a, alu_b, alu_ctrl,
        output pc_plus4, reg_dst, jump, jump_reg, jump_link,
        output branch, mem_read, mem_to_reg, mem_write,
        output reg_write, alu_src, alu_ctrl_d, illegal,
        output alu_out, alu_zero, halted, print_valid, print_data
    );
endinterface

// File: rtl/mips_decode_alu_unit.sv
// MIPS decode control, execute ALU, fetch PC+4 adder and
// a registered syscall monitor for halt/print.
module mips_decode_alu_unit #(
    parameter logic [31:0] HALT_CODE  = 32'd10,
    parameter logic [31:0] PRINT_CODE = 32'd1
) (
    input logic                    clk,
    input logic                    rst_n,
    mips_decode_alu_unit_if.slave  bus
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       isSyscall;

    assign op        = bus.instr[31:26];
    assign funct     = bus.instr[5:0];
    assign isSyscall = (op == 6'h00) && (funct == 6'h0C);

    assign bus.pc_plus4 = bus.pc + 32'd4;

    logic [1:0] regDst;
    logic       jump;
    logic       jumpReg;
    logic       jumpLink;
    logic       branch;
    logic       memRead;
    logic       memToReg;
    logic       memWrite;
    logic       regWrite;
    logic       aluSrc;
    logic [2:0] aluCtrlD;
    logic       illegal;

    always_comb begin
        regDst   = 2'b00;
        jump     = 1'b0;
        jumpReg  = 1'b0;
        jumpLink = 1'b0;
        branch   = 1'b0;
        memRead  = 1'b0;
        memToReg = 1'b0;
        memWrite = 1'b0;
        regWrite = 1'b0;
        aluSrc   = 1'b0;
        aluCtrlD = 3'b000;
        illegal  = 1'b0;
        unique case (op)
            6'h00: begin
                unique case (funct)
                    6'h20, 6'h21: begin
                        regWrite = 1'b1; regDst = 2'b01; aluCtrlD = 3'b010;
                    end
                    6'h22, 6'h23: begin
                        regWrite = 1'b1; regDst = 2'b01; aluCtrlD = 3'b110;
                    end
                    6'h24: begin
                        regWrite = 1'b1; regDst = 2'b01; aluCtrlD = 3'b000;
                    end
                    6'h25: begin
                        regWrite = 1'b1; regDst = 2'b01; aluCtrlD = 3'b001;
                    end
                    6'h26: begin
                        regWrite = 1'b1; regDst = 2'b01; aluCtrlD = 3'b011;
                    end
                    6'h27: begin
                        regWrite = 1'b1; regDst = 2'b01; aluCtrlD = 3'b100;
                    end
                    6'h2A: begin
                        regWrite = 1'b1; regDst = 2'b01; aluCtrlD = 3'b111;
                    end
                    6'h08: begin
                        jump = 1'b1; jumpReg = 1'b1;
                    end
                    6'h0C: ;
                    // only the all-zero word is accepted as a shift (NOP)
                    6'h00: illegal = (bus.instr != 32'h0);
                    default: illegal = 1'b1;
                endcase
            end
            6'h08, 6'h09: begin
                aluSrc = 1'b1; regWrite = 1'b1; aluCtrlD = 3'b010;
            end
            6'h0C: begin
                aluSrc = 1'b1; regWrite = 1'b1; aluCtrlD = 3'b000;
            end
            6'h0D: begin
                aluSrc = 1'b1; regWrite = 1'b1; aluCtrlD = 3'b001;
            end
            6'h0E: begin
                aluSrc = 1'b1; regWrite = 1'b1; aluCtrlD = 3'b011;
            end
            6'h0A: begin
                aluSrc = 1'b1; regWrite = 1'b1; aluCtrlD = 3'b111;
            end
            6'h0F: begin
                aluSrc = 1'b1; regWrite = 1'b1; aluCtrlD = 3'b101;
            end
            6'h23: begin
                aluSrc = 1'b1; regWrite = 1'b1; aluCtrlD = 3'b010;
                memRead = 1'b1; memToReg = 1'b1;
            end
            6'h2B: begin
                aluSrc = 1'b1; memWrite = 1'b1; aluCtrlD = 3'b010;
            end
            6'h04: begin
                branch = 1'b1; aluCtrlD = 3'b110;
            end
            6'h02: jump = 1'b1;
            6'h03: begin
                jump = 1'b1; jumpLink = 1'b1;
                regWrite = 1'b1; regDst = 2'b10;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign bus.reg_dst    = regDst;
    assign bus.jump       = jump;
    assign bus.jump_reg   = jumpReg;
    assign bus.jump_link  = jumpLink;
    assign bus.branch     = branch;
    assign bus.mem_read   = memRead;
    assign bus.mem_to_reg = memToReg;
    assign bus.mem_write  = memWrite;
    assign bus.reg_write  = regWrite;
    assign bus.alu_src    = aluSrc;
    assign bus.alu_ctrl_d = aluCtrlD;
    assign bus.illegal    = illegal;

    logic [31:0] aluRes;

    always_comb begin
        aluRes = 32'h0;
        unique case (bus.alu_ctrl)
            3'b000: aluRes = bus.alu_a & bus.alu_b;
            3'b001: aluRes = bus.alu_a | bus.alu_b;
            3'b010: aluRes = bus.alu_a + bus.alu_b;
            3'b011: aluRes = bus.alu_a ^ bus.alu_b;
            3'b100: aluRes = ~(bus.alu_a | bus.alu_b);
            3'b101: aluRes = {bus.alu_b[15:0], 16'h0000};
            3'b110: aluRes = bus.alu_a - bus.alu_b;
            3'b111: aluRes = {31'h0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            default: aluRes = 32'h0;
        endcase
    end

    assign bus.alu_out  = aluRes;
    assign bus.alu_zero = (aluRes == 32'h0);

    logic        halted;
    logic        printValid;
    logic [31:0] printData;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted     <= 1'b0;
            printValid <= 1'b0;
            printData  <= 32'h0;
        end else begin
            printValid <= 1'b0;
            if (isSyscall && !halted) begin
                if (bus.syscall_info == HALT_CODE) begin
                    halted <= 1'b1;
                end else if (bus.syscall_info == PRINT_CODE) begin
                    printValid <= 1'b1;
                    printData  <= bus.syscall_arg;
                end
            end
        end
    end

    assign bus.halted      = halted;
    assign bus.print_valid = printValid;
    assign bus.print_data  = printData;

endmodule

// File: tb/tb_mips_decode_alu_unit.sv
// Directed-vector bench for mips_decode_alu_unit.
// Checks ALU, PC adder, decode table and syscall monitor.
module tb_mips_decode_alu_unit;

    logic clk;
    logic rst_n;
    int   nVec;
    int   nErr;

    mips_decode_alu_unit_if bus ();

    mips_decode_alu_unit #(
        .HALT_CODE(32'd10),
        .PRINT_CODE(32'd1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ctlVec();
        return {17'h0, bus.reg_dst,
                bus.jump, bus.jump_reg, bus.jump_link, bus.branch,
                bus.mem_read, bus.mem_to_reg, bus.mem_write,
                bus.reg_write, bus.alu_src,
                bus.alu_ctrl_d, bus.illegal};
    endfunction

    task automatic aluCase(input string tag, input logic [2:0] c,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input logic expZ);
        bus.alu_ctrl = c;
        bus.alu_a    = a;
        bus.alu_b    = b;
        #1;
        chk(tag, bus.alu_out, exp);
        chk({tag, "_z"}, {31'h0, bus.alu_zero}, {31'h0, expZ});
    endtask

    // expected = {regDst, jump, jumpReg, jumpLink, branch, memRead,
    //             memToReg, memWrite, regWrite, aluSrc, ctrl, illegal}
    task automatic decCase(input string tag, input logic [31:0] ins,
                           input logic [1:0] rd, input logic [8:0] f,
                           input logic [2:0] c, input logic ill);
        bus.instr = ins;
        #1;
        chk(tag, ctlVec(), {17'h0, rd, f, c, ill});
    endtask

    initial begin
        nVec = 0;
        nErr = 0;
        rst_n            = 1'b0;
        bus.pc           = 32'h0;
        bus.instr        = 32'h0;
        bus.syscall_info = 32'h0;
        bus.syscall_arg  = 32'h0;
        bus.alu_a        = 32'h0;
        bus.alu_b        = 32'h0;
        bus.alu_ctrl     = 3'b000;
        #2;
        chk("rst_halted", {31'h0, bus.halted}, 32'h0);
        chk("rst_pvalid", {31'h0, bus.print_valid}, 32'h0);
        chk("rst_pdata", bus.print_data, 32'h0);

        aluCase("add_ovf", 3'b010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0);
        aluCase("sub_eq", 3'b110, 32'd5, 32'd5, 32'h0, 1'b1);
        aluCase("slt_neg", 3'b111, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0);
        aluCase("slt_pos", 3'b111, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b1);
        aluCase("lui", 3'b101, 32'hDEAD0000, 32'h00001234, 32'h12340000, 1'b0);
        aluCase("nor", 3'b100, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0);
        aluCase("and", 3'b000, 32'hF0F0FFFF, 32'h0FF0000F, 32'h00F0000F, 1'b0);
        aluCase("or", 3'b001, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0);
        aluCase("xor", 3'b011, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0);

        bus.pc = 32'h00400000;
        #1 chk("pc4", bus.pc_plus4, 32'h00400004);
        bus.pc = 32'hFFFFFFFC;
        #1 chk("pc4_wrap", bus.pc_plus4, 32'h00000000);

        decCase("d_add", 32'h02328020, 2'b01, 9'b000000010, 3'b010, 1'b0);
        decCase("d_sub", 32'h02328022, 2'b01, 9'b000000010, 3'b110, 1'b0);
        decCase("d_slt", 32'h0232802A, 2'b01, 9'b000000010, 3'b111, 1'b0);
        decCase("d_lw", 32'h8C880004, 2'b00, 9'b000011011, 3'b010, 1'b0);
        decCase("d_sw", 32'hAC880004, 2'b00, 9'b000000101, 3'b010, 1'b0);
        decCase("d_lui", 32'h3C011234, 2'b00, 9'b000000011, 3'b101, 1'b0);
        decCase("d_ori", 32'h34210001, 2'b00, 9'b000000011, 3'b001, 1'b0);
        decCase("d_jal", 32'h0C100000, 2'b10, 9'b101000010, 3'b000, 1'b0);
        decCase("d_j", 32'h08100000, 2'b00, 9'b100000000, 3'b000, 1'b0);
        decCase("d_jr", 32'h03E00008, 2'b00, 9'b110000000, 3'b000, 1'b0);
        decCase("d_beq", 32'h10850003, 2'b00, 9'b000100000, 3'b110, 1'b0);
        decCase("d_badop", 32'hFC000000, 2'b00, 9'b000000000, 3'b000, 1'b1);
        decCase("d_badfn", 32'h0232803F, 2'b00, 9'b000000000, 3'b000, 1'b1);
        decCase("d_sll", 32'h00108080, 2'b00, 9'b000000000, 3'b000, 1'b1);
        decCase("d_nop", 32'h00000000, 2'b00, 9'b000000000, 3'b000, 1'b0);
        decCase("d_sys", 32'h0000000C, 2'b00, 9'b000000000, 3'b000, 1'b0);

        bus.instr = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;

        // print syscall held for exactly one cycle
        @(negedge clk);
        bus.instr        = 32'h0000000C;
        bus.syscall_info = 32'd1;
        bus.syscall_arg  = 32'd42;
        @(negedge clk);
        chk("pr_valid", {31'h0, bus.print_valid}, 32'h1);
        chk("pr_data", bus.print_data, 32'd42);
        bus.instr = 32'h0;
        @(negedge clk);
        chk("pr_drop", {31'h0, bus.print_valid}, 32'h0);

        // unknown code is ignored
        bus.instr        = 32'h0000000C;
        bus.syscall_info = 32'd5;
        @(negedge clk);
        chk("oth_valid", {31'h0, bus.print_valid}, 32'h0);
        chk("oth_halt", {31'h0, bus.halted}, 32'h0);

        // halt, then a print that must be ignored
        bus.syscall_info = 32'd10;
        @(negedge clk);
        chk("halt_set", {31'h0, bus.halted}, 32'h1);
        bus.syscall_info = 32'd1;
        bus.syscall_arg  = 32'd7;
        @(negedge clk);
        chk("halt_sticky", {31'h0, bus.halted}, 32'h1);
        chk("halt_noprint", {31'h0, bus.print_valid}, 32'h0);
        bus.instr = 32'h0;
        @(negedge clk);
        chk("halt_hold", {31'h0, bus.halted}, 32'h1);
        #2 rst_n = 1'b0;
        #1 chk("halt_arst", {31'h0, bus.halted}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // reset asserted while the strobe is high
        bus.instr        = 32'h0000000C;
        bus.syscall_info = 32'd1;
        bus.syscall_arg  = 32'h12345678;
        @(posedge clk);
        #1;
        bus.instr = 32'h0;
        chk("mid_valid", {31'h0, bus.print_valid}, 32'h1);
        chk("mid_data", bus.print_data, 32'h12345678);
        rst_n = 1'b0;
        #1;
        chk("mid_drop", {31'h0, bus.print_valid}, 32'h0);
        chk("mid_dclr", bus.print_data, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
